reservation_station: RTL and testbench

- Unified reservation station between dispatch/map-table lookup and the functional units of the P6-style out-of-order core.
- Accepts one decoded instruction per cycle and drives the map-table lookup (source/dest architectural indices, dest ROB tag).
- Captures the returned operand tags and ready bits, wakes operands on CDB broadcasts, and issues one ready instruction per cycle to the FU via valid/ready.
- Drives the map-table stall so the table is only written when dispatch is accepted.

---
 rtl/reservation_station_pkg.sv | 52 +++++
 rtl/reservation_station_psel.sv | 27 ++
 rtl/reservation_station.sv | 161 ++++++++++++++++
 tb/tb_reservation_station.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared sizing, entry layout and operand capture/wakeup helpers for the reservation station.
// Optional feature macro RS_AGE_SELECT_EN adds a per-entry age field for oldest-first issue.
package reservation_station_pkg;

  localparam int unsigned RS_DEPTH  = 8;
  localparam int unsigned TAG_W     = 5;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned PAYLOAD_W = 64;
  localparam int unsigned IDX_W     = $clog2(RS_DEPTH);
  localparam int unsigned CNT_W     = IDX_W + 1;

  // One source operand: ROB tag, ready bit, and whether the value comes from the ROB.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             ready;
    logic             from_rob;
  } tag_packet_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     rob_tag;
    tag_packet_t          rs1;
    tag_packet_t          rs2;
`ifdef RS_AGE_SELECT_EN
    logic [IDX_W-1:0]     age;
`endif
    logic [PAYLOAD_W-1:0] payload;
  } rs_entry_t;

  // Capture a map-table result; a same-cycle CDB hit on the tag counts as ready.
  function automatic tag_packet_t capture_operand(input logic             tag_valid,
                                                  input logic             rob_ready,
                                                  input logic [TAG_W-1:0] tag,
                                                  input logic             cdb_valid,
                                                  input logic [TAG_W-1:0] cdb_tag);
    tag_packet_t op;
    op.tag      = tag_valid ? tag : '0;
    op.from_rob = tag_valid;
    op.ready    = !tag_valid || rob_ready || (cdb_valid && (cdb_tag == tag));
    return op;
  endfunction

  function automatic tag_packet_t wake_operand(input tag_packet_t      op,
                                               input logic             cdb_valid,
                                               input logic [TAG_W-1:0] cdb_tag);
    tag_packet_t woken;
    woken = op;
    if (!op.ready && cdb_valid && (op.tag == cdb_tag)) woken.ready = 1'b1;
    return woken;
  endfunction

endpackage

// File: rtl/reservation_station_psel.sv
// Lowest-index priority selector: one-hot grant, encoded index and any-request flag.
module reservation_station_psel #(
  parameter int unsigned N = 8,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] idx_c,
  output logic          any_c
);

  always_comb begin
    logic found;
    found = 1'b0;
    gnt_c = '0;
    idx_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        gnt_c[i] = 1'b1;
        idx_c    = IW'(i);
        found    = 1'b1;
      end
    end
    any_c = found;
  end

endmodule

// File: rtl/reservation_station.sv
// Unified reservation station: dispatch capture, CDB wakeup and single-issue select to the FU.
// RS_AGE_SELECT_EN selects the oldest ready entry instead of the lowest-index one.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 squash,
  input  logic                 disp_valid,
  output logic                 disp_ready,
  input  logic [REG_IDX_W-1:0] disp_rs1_idx,
  input  logic [REG_IDX_W-1:0] disp_rs2_idx,
  input  logic [REG_IDX_W-1:0] disp_dest_idx,
  input  logic                 disp_dest_valid,
  input  logic [TAG_W-1:0]     disp_rob_tag,
  input  logic [PAYLOAD_W-1:0] disp_payload,
  output logic [REG_IDX_W-1:0] mt_rs1_idx,
  output logic [REG_IDX_W-1:0] mt_rs2_idx,
  output logic [REG_IDX_W-1:0] mt_dest_idx,
  output logic                 mt_dest_tag_valid,
  output logic [TAG_W-1:0]     mt_dest_tag,
  output logic                 mt_stall,
  input  logic                 mt_rs1_tag_valid,
  input  logic                 mt_rs1_ready,
  input  logic                 mt_rs2_tag_valid,
  input  logic                 mt_rs2_ready,
  input  logic [TAG_W-1:0]     mt_rs1_tag,
  input  logic [TAG_W-1:0]     mt_rs2_tag,
  input  logic                 cdb_valid,
  input  logic [TAG_W-1:0]     cdb_tag,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  output logic [TAG_W-1:0]     iss_rob_tag,
  output logic [TAG_W-1:0]     iss_rs1_tag,
  output logic [TAG_W-1:0]     iss_rs2_tag,
  output logic                 iss_rs1_from_rob,
  output logic                 iss_rs2_from_rob,
  output logic [PAYLOAD_W-1:0] iss_payload,
  output logic [CNT_W-1:0]     free_count
);

  rs_entry_t            entries [RS_DEPTH];
  logic [CNT_W-1:0]     free_cnt_q;
  logic [RS_DEPTH-1:0]  free_vec;
  logic [RS_DEPTH-1:0]  ready_vec;
  logic [RS_DEPTH-1:0]  sel_req;
  logic [RS_DEPTH-1:0]  alloc_gnt;
  logic [IDX_W-1:0]     alloc_idx_unused;
  logic                 alloc_any;
  logic [RS_DEPTH-1:0]  iss_gnt;
  logic [IDX_W-1:0]     iss_idx;
  logic                 iss_any;
  logic                 accept;
  logic                 fire;
  rs_entry_t            new_entry;
  rs_entry_t            sel_entry;

  assign free_count = free_cnt_q;
  assign disp_ready = (free_cnt_q != '0);
  // Squash (and reset) block the map-table write so it never sees a dropped dispatch.
  assign accept     = disp_valid && disp_ready && alloc_any && !squash && !reset;
  assign fire       = iss_any && iss_ready;

  assign mt_rs1_idx        = disp_rs1_idx;
  assign mt_rs2_idx        = disp_rs2_idx;
  assign mt_dest_idx       = disp_dest_idx;
  assign mt_dest_tag       = disp_rob_tag;
  assign mt_dest_tag_valid = accept && disp_dest_valid;
  assign mt_stall          = !accept;

  always_comb begin
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      free_vec[i]  = !entries[i].valid;
      ready_vec[i] = entries[i].valid && entries[i].rs1.ready && entries[i].rs2.ready;
    end
  end

`ifdef RS_AGE_SELECT_EN
  // Restrict the select to ready entries carrying the maximum age; psel breaks ties low.
  always_comb begin
    logic [IDX_W-1:0] max_age;
    max_age = '0;
    sel_req = '0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      if (ready_vec[i] && (entries[i].age > max_age)) max_age = entries[i].age;
    end
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      sel_req[i] = ready_vec[i] && (entries[i].age == max_age);
    end
  end
`else
  assign sel_req = ready_vec;
`endif

  reservation_station_psel #(.N(RS_DEPTH)) u_alloc_sel (
    .req   (free_vec),
    .gnt_c (alloc_gnt),
    .idx_c (alloc_idx_unused),
    .any_c (alloc_any)
  );

  reservation_station_psel #(.N(RS_DEPTH)) u_issue_sel (
    .req   (sel_req),
    .gnt_c (iss_gnt),
    .idx_c (iss_idx),
    .any_c (iss_any)
  );

  always_comb begin
    new_entry         = '0;
    new_entry.valid   = 1'b1;
    new_entry.rob_tag = disp_rob_tag;
    new_entry.payload = disp_payload;
    new_entry.rs1     = capture_operand(mt_rs1_tag_valid, mt_rs1_ready, mt_rs1_tag, cdb_valid, cdb_tag);
    new_entry.rs2     = capture_operand(mt_rs2_tag_valid, mt_rs2_ready, mt_rs2_tag, cdb_valid, cdb_tag);
  end

  assign sel_entry = entries[iss_idx];

  // Issue bus is zero whenever nothing is selected.
  always_comb begin
    iss_valid        = iss_any;
    iss_rob_tag      = '0;
    iss_rs1_tag      = '0;
    iss_rs2_tag      = '0;
    iss_rs1_from_rob = 1'b0;
    iss_rs2_from_rob = 1'b0;
    iss_payload      = '0;
    if (iss_any) begin
      iss_rob_tag      = sel_entry.rob_tag;
      iss_rs1_tag      = sel_entry.rs1.tag;
      iss_rs2_tag      = sel_entry.rs2.tag;
      iss_rs1_from_rob = sel_entry.rs1.from_rob;
      iss_rs2_from_rob = sel_entry.rs2.from_rob;
      iss_payload      = sel_entry.payload;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) entries[i] <= '0;
      free_cnt_q <= CNT_W'(RS_DEPTH);
    end else begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        if (accept && alloc_gnt[i]) begin
          entries[i] <= new_entry;
        end else if (fire && iss_gnt[i]) begin
          entries[i].valid <= 1'b0;
        end else if (entries[i].valid) begin
          entries[i].rs1 <= wake_operand(entries[i].rs1, cdb_valid, cdb_tag);
          entries[i].rs2 <= wake_operand(entries[i].rs2, cdb_valid, cdb_tag);
`ifdef RS_AGE_SELECT_EN
          if (accept && (entries[i].age != '1)) entries[i].age <= entries[i].age + IDX_W'(1);
`endif
        end
      end
      free_cnt_q <= free_cnt_q - CNT_W'(accept) + CNT_W'(fire);
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios plus randomized traffic
// checked against a slot-level behavioural model.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic                 clock;
  logic                 reset, squash;
  logic                 disp_valid, disp_ready;
  logic [REG_IDX_W-1:0] disp_rs1_idx, disp_rs2_idx, disp_dest_idx;
  logic                 disp_dest_valid;
  logic [TAG_W-1:0]     disp_rob_tag;
  logic [PAYLOAD_W-1:0] disp_payload;
  logic [REG_IDX_W-1:0] mt_rs1_idx, mt_rs2_idx, mt_dest_idx;
  logic                 mt_dest_tag_valid, mt_stall;
  logic [TAG_W-1:0]     mt_dest_tag;
  logic                 mt_rs1_tag_valid, mt_rs1_ready, mt_rs2_tag_valid, mt_rs2_ready;
  logic [TAG_W-1:0]     mt_rs1_tag, mt_rs2_tag;
  logic                 cdb_valid;
  logic [TAG_W-1:0]     cdb_tag;
  logic                 iss_valid, iss_ready;
  logic [TAG_W-1:0]     iss_rob_tag, iss_rs1_tag, iss_rs2_tag;
  logic                 iss_rs1_from_rob, iss_rs2_from_rob;
  logic [PAYLOAD_W-1:0] iss_payload;
  logic [CNT_W-1:0]     free_count;

  int checks = 0;
  int errors = 0;

  // Model: one record per slot, plus a dispatch sequence number for age ordering.
  bit                   m_v  [RS_DEPTH];
  logic [TAG_W-1:0]     m_rob[RS_DEPTH];
  logic [TAG_W-1:0]     m_t1 [RS_DEPTH];
  logic [TAG_W-1:0]     m_t2 [RS_DEPTH];
  bit                   m_r1 [RS_DEPTH];
  bit                   m_r2 [RS_DEPTH];
  bit                   m_f1 [RS_DEPTH];
  bit                   m_f2 [RS_DEPTH];
  logic [PAYLOAD_W-1:0] m_pay[RS_DEPTH];
  int                   m_seq[RS_DEPTH];
  int                   seq_ctr = 0;

  reservation_station dut (
    .clock(clock), .reset(reset), .squash(squash),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_rs1_idx(disp_rs1_idx), .disp_rs2_idx(disp_rs2_idx), .disp_dest_idx(disp_dest_idx),
    .disp_dest_valid(disp_dest_valid), .disp_rob_tag(disp_rob_tag), .disp_payload(disp_payload),
    .mt_rs1_idx(mt_rs1_idx), .mt_rs2_idx(mt_rs2_idx), .mt_dest_idx(mt_dest_idx),
    .mt_dest_tag_valid(mt_dest_tag_valid), .mt_dest_tag(mt_dest_tag), .mt_stall(mt_stall),
    .mt_rs1_tag_valid(mt_rs1_tag_valid), .mt_rs1_ready(mt_rs1_ready),
    .mt_rs2_tag_valid(mt_rs2_tag_valid), .mt_rs2_ready(mt_rs2_ready),
    .mt_rs1_tag(mt_rs1_tag), .mt_rs2_tag(mt_rs2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rob_tag(iss_rob_tag),
    .iss_rs1_tag(iss_rs1_tag), .iss_rs2_tag(iss_rs2_tag),
    .iss_rs1_from_rob(iss_rs1_from_rob), .iss_rs2_from_rob(iss_rs2_from_rob),
    .iss_payload(iss_payload), .free_count(free_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int m_free();
    int n = 0;
    for (int i = 0; i < RS_DEPTH; i++) if (!m_v[i]) n++;
    return n;
  endfunction

  // Which slot should be on the issue bus: lowest ready slot, or earliest dispatched one.
  function automatic int m_sel();
    int best = -1;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (m_v[i] && m_r1[i] && m_r2[i]) begin
`ifdef RS_AGE_SELECT_EN
        if (best < 0 || m_seq[i] < m_seq[best]) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    end
    return best;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic m_step();
    int  sel, slot;
    bit  acc, fire;
    if (reset || squash) begin
      for (int i = 0; i < RS_DEPTH; i++) m_v[i] = 1'b0;
      return;
    end
    sel  = m_sel();
    fire = (sel >= 0) && iss_ready;
    acc  = disp_valid && (m_free() != 0);
    slot = -1;
    for (int i = 0; i < RS_DEPTH; i++) if (!m_v[i] && slot < 0) slot = i;
    if (cdb_valid) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (m_v[i] && !m_r1[i] && m_t1[i] == cdb_tag) m_r1[i] = 1'b1;
        if (m_v[i] && !m_r2[i] && m_t2[i] == cdb_tag) m_r2[i] = 1'b1;
      end
    end
    if (fire) m_v[sel] = 1'b0;
    if (acc) begin
      m_v[slot]   = 1'b1;
      m_rob[slot] = disp_rob_tag;
      m_pay[slot] = disp_payload;
      m_f1[slot]  = mt_rs1_tag_valid;
      m_f2[slot]  = mt_rs2_tag_valid;
      m_t1[slot]  = mt_rs1_tag;
      m_t2[slot]  = mt_rs2_tag;
      m_r1[slot]  = !mt_rs1_tag_valid || mt_rs1_ready || (cdb_valid && cdb_tag == mt_rs1_tag);
      m_r2[slot]  = !mt_rs2_tag_valid || mt_rs2_ready || (cdb_valid && cdb_tag == mt_rs2_tag);
      m_seq[slot] = seq_ctr;
      seq_ctr++;
    end
  endtask

  task automatic tick();
    m_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    squash = 0; disp_valid = 0; disp_dest_valid = 0;
    disp_rs1_idx = '0; disp_rs2_idx = '0; disp_dest_idx = '0;
    disp_rob_tag = '0; disp_payload = '0;
    mt_rs1_tag_valid = 0; mt_rs1_ready = 0; mt_rs2_tag_valid = 0; mt_rs2_ready = 0;
    mt_rs1_tag = '0; mt_rs2_tag = '0; cdb_valid = 0; cdb_tag = '0;
  endtask

  task automatic set_disp(input logic [TAG_W-1:0] rob,
                          input logic tv1, input logic r1, input logic [TAG_W-1:0] t1,
                          input logic tv2, input logic r2, input logic [TAG_W-1:0] t2,
                          input logic [PAYLOAD_W-1:0] pay);
    disp_valid = 1; disp_dest_valid = 1; disp_rob_tag = rob; disp_payload = pay;
    disp_rs1_idx = 5'd1; disp_rs2_idx = 5'd2; disp_dest_idx = 5'd3;
    mt_rs1_tag_valid = tv1; mt_rs1_ready = r1; mt_rs1_tag = t1;
    mt_rs2_tag_valid = tv2; mt_rs2_ready = r2; mt_rs2_tag = t2;
  endtask

  task automatic test_reset();
    idle_inputs(); iss_ready = 1; reset = 1;
    tick(); tick();
    reset = 0;
    @(negedge clock);
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid got=%0b exp=0", iss_valid); end
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready got=%0b exp=1", disp_ready); end
    checks++; if (free_count !== CNT_W'(RS_DEPTH)) begin errors++; $display("FAIL reset_free_count got=%0d exp=%0d", free_count, RS_DEPTH); end
    checks++; if (iss_rob_tag !== '0 || iss_payload !== '0) begin errors++; $display("FAIL reset_iss_data got=%0h/%0h exp=0/0", iss_rob_tag, iss_payload); end
    tick();
  endtask

  task automatic test_basic_issue();
    iss_ready = 1;
    set_disp(5'd3, 0, 0, '0, 0, 0, '0, 64'hA5A5_0000_1234_0003);
    @(negedge clock);
    checks++; if (mt_stall !== 1'b0 || mt_dest_tag_valid !== 1'b1) begin errors++; $display("FAIL basic_mt_ctrl got stall=%0b dtv=%0b exp 0/1", mt_stall, mt_dest_tag_valid); end
    checks++; if (mt_dest_tag !== 5'd3 || mt_dest_idx !== 5'd3 || mt_rs1_idx !== 5'd1) begin errors++; $display("FAIL basic_mt_fields got tag=%0d dest=%0d rs1=%0d exp 3/3/1", mt_dest_tag, mt_dest_idx, mt_rs1_idx); end
    tick();
    idle_inputs();
    @(negedge clock);
    checks++; if (iss_valid !== 1'b1 || iss_rob_tag !== 5'd3) begin errors++; $display("FAIL basic_issue got v=%0b tag=%0d exp 1/3", iss_valid, iss_rob_tag); end
    checks++; if (iss_rs1_from_rob !== 1'b0 || iss_rs2_from_rob !== 1'b0) begin errors++; $display("FAIL basic_from_rob got %0b%0b exp 00", iss_rs1_from_rob, iss_rs2_from_rob); end
    checks++; if (free_count !== CNT_W'(7)) begin errors++; $display("FAIL basic_count_dec got=%0d exp=7", free_count); end
    checks++; if (iss_payload !== 64'hA5A5_0000_1234_0003) begin errors++; $display("FAIL basic_payload got=%0h", iss_payload); end
    tick();
    @(negedge clock);
    checks++; if (iss_valid !== 1'b0 || free_count !== CNT_W'(8)) begin errors++; $display("FAIL basic_drain got v=%0b cnt=%0d exp 0/8", iss_valid, free_count); end
    tick();
  endtask

  task automatic test_cdb_wakeup();
    iss_ready = 1;
    set_disp(5'd4, 1, 0, 5'd5, 0, 0, '0, 64'h44);
    tick();
    idle_inputs();
    @(negedge clock);
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL wake_early got=%0b exp=0", iss_valid); end
    tick();
    cdb_valid = 1; cdb_tag = 5'd5;
    @(negedge clock);
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL wake_same_cycle got=%0b exp=0", iss_valid); end
    tick();
    idle_inputs();
    @(negedge clock);
    checks++; if (iss_valid !== 1'b1 || iss_rob_tag !== 5'd4) begin errors++; $display("FAIL wake_issue got v=%0b tag=%0d exp 1/4", iss_valid, iss_rob_tag); end
    checks++; if (iss_rs1_from_rob !== 1'b1 || iss_rs1_tag !== 5'd5 || iss_rs2_from_rob !== 1'b0) begin errors++; $display("FAIL wake_operands got f1=%0b t1=%0d f2=%0b exp 1/5/0", iss_rs1_from_rob, iss_rs1_tag, iss_rs2_from_rob); end
    tick();
  endtask

  task automatic test_dispatch_bypass();
    iss_ready = 1;
    set_disp(5'd9, 0, 0, '0, 1, 0, 5'd7, 64'h99);
    cdb_valid = 1; cdb_tag = 5'd7;
    tick();
    idle_inputs();
    @(negedge clock);
    checks++; if (iss_valid !== 1'b1 || iss_rob_tag !== 5'd9) begin errors++; $display("FAIL bypass_issue got v=%0b tag=%0d exp 1/9", iss_valid, iss_rob_tag); end
    checks++; if (iss_rs2_from_rob !== 1'b1 || iss_rs2_tag !== 5'd7) begin errors++; $display("FAIL bypass_rs2 got f=%0b t=%0d exp 1/7", iss_rs2_from_rob, iss_rs2_tag); end
    tick();
  endtask

  task automatic test_full_stall();
    iss_ready = 0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      set_disp(TAG_W'(10 + i), 1, 0, TAG_W'(16 + i), 0, 0, '0, 64'(i));
      tick();
    end
    set_disp(5'd30, 0, 0, '0, 0, 0, '0, 64'h30);
    @(negedge clock);
    checks++; if (disp_ready !== 1'b0 || mt_stall !== 1'b1 || mt_dest_tag_valid !== 1'b0) begin errors++; $display("FAIL full_stall got rdy=%0b stall=%0b dtv=%0b exp 0/1/0", disp_ready, mt_stall, mt_dest_tag_valid); end
    checks++; if (free_count !== '0 || iss_valid !== 1'b0) begin errors++; $display("FAIL full_state got cnt=%0d v=%0b exp 0/0", free_count, iss_valid); end
    tick();
    idle_inputs(); cdb_valid = 1; cdb_tag = 5'd19;
    tick();
    idle_inputs(); iss_ready = 1;
    @(negedge clock);
    checks++; if (iss_valid !== 1'b1 || iss_rob_tag !== 5'd13 || disp_ready !== 1'b0) begin errors++; $display("FAIL full_issue got v=%0b tag=%0d rdy=%0b exp 1/13/0", iss_valid, iss_rob_tag, disp_ready); end
    tick();
    iss_ready = 0;
    @(negedge clock);
    checks++; if (disp_ready !== 1'b1 || free_count !== CNT_W'(1)) begin errors++; $display("FAIL full_reopen got rdy=%0b cnt=%0d exp 1/1", disp_ready, free_count); end
    squash = 1;
    tick();
    squash = 0;
  endtask

  task automatic test_hold_and_squash();
    iss_ready = 0;
    set_disp(5'd12, 0, 0, '0, 1, 1, 5'd2, 64'h1212);
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++; if (iss_valid !== 1'b1 || iss_rob_tag !== 5'd12 || iss_rs2_from_rob !== 1'b1) begin errors++; $display("FAIL hold_c%0d got v=%0b tag=%0d f2=%0b exp 1/12/1", c, iss_valid, iss_rob_tag, iss_rs2_from_rob); end
      tick();
    end
    squash = 1;
    set_disp(5'd20, 0, 0, '0, 0, 0, '0, 64'h20);
    @(negedge clock);
    checks++; if (mt_stall !== 1'b1 || mt_dest_tag_valid !== 1'b0) begin errors++; $display("FAIL squash_stall got stall=%0b dtv=%0b exp 1/0", mt_stall, mt_dest_tag_valid); end
    tick();
    idle_inputs();
    @(negedge clock);
    checks++; if (iss_valid !== 1'b0 || free_count !== CNT_W'(8)) begin errors++; $display("FAIL squash_clear got v=%0b cnt=%0d exp 0/8", iss_valid, free_count); end
  endtask

  task automatic test_age_order();
    logic [TAG_W-1:0] exp_first, exp_second;
`ifdef RS_AGE_SELECT_EN
    exp_first = 5'd3; exp_second = 5'd4;
`else
    exp_first = 5'd4; exp_second = 5'd3;
`endif
    iss_ready = 0;
    set_disp(5'd1, 1, 0, 5'd1, 0, 0, '0, 64'h1); tick();
    set_disp(5'd2, 1, 0, 5'd2, 0, 0, '0, 64'h2); tick();
    set_disp(5'd3, 1, 0, 5'd3, 0, 0, '0, 64'h3); tick();
    idle_inputs(); cdb_valid = 1; cdb_tag = 5'd1; tick();
    idle_inputs(); iss_ready = 1;
    @(negedge clock);
    checks++; if (iss_valid !== 1'b1 || iss_rob_tag !== 5'd1) begin errors++; $display("FAIL age_first_slot got v=%0b tag=%0d exp 1/1", iss_valid, iss_rob_tag); end
    tick();
    iss_ready = 0;
    set_disp(5'd4, 0, 0, '0, 0, 0, '0, 64'h4);
    cdb_valid = 1; cdb_tag = 5'd3;
    tick();
    idle_inputs(); iss_ready = 1;
    @(negedge clock);
    checks++; if (iss_rob_tag !== exp_first) begin errors++; $display("FAIL age_order_1 got=%0d exp=%0d", iss_rob_tag, exp_first); end
    tick();
    @(negedge clock);
    checks++; if (iss_rob_tag !== exp_second) begin errors++; $display("FAIL age_order_2 got=%0d exp=%0d", iss_rob_tag, exp_second); end
    tick();
    squash = 1; tick(); squash = 0;
  endtask

  task automatic test_random();
    int s;
    bit exp_rdy, exp_acc;
    for (int cyc = 0; cyc < 400; cyc++) begin
      disp_valid       = ($urandom_range(0, 9) < 6);
      disp_dest_valid  = $urandom_range(0, 1) == 1;
      disp_rob_tag     = TAG_W'($urandom_range(0, 31));
      disp_rs1_idx     = REG_IDX_W'($urandom_range(0, 31));
      disp_rs2_idx     = REG_IDX_W'($urandom_range(0, 31));
      disp_dest_idx    = REG_IDX_W'($urandom_range(0, 31));
      disp_payload     = {$urandom, $urandom};
      mt_rs1_tag_valid = $urandom_range(0, 2) != 0;
      mt_rs1_ready     = $urandom_range(0, 2) == 0;
      mt_rs1_tag       = TAG_W'($urandom_range(0, 7));
      mt_rs2_tag_valid = $urandom_range(0, 2) != 0;
      mt_rs2_ready     = $urandom_range(0, 2) == 0;
      mt_rs2_tag       = TAG_W'($urandom_range(0, 7));
      cdb_valid        = $urandom_range(0, 1) == 1;
      cdb_tag          = TAG_W'($urandom_range(0, 7));
      iss_ready        = ($urandom_range(0, 9) < 6);
      squash           = ($urandom_range(0, 49) == 0);
      @(negedge clock);
      s       = m_sel();
      exp_rdy = (m_free() != 0);
      exp_acc = disp_valid && exp_rdy && !squash;
      checks++; if (disp_ready !== exp_rdy) begin errors++; $display("FAIL rnd_disp_ready cyc=%0d got=%0b exp=%0b", cyc, disp_ready, exp_rdy); end
      checks++; if (free_count !== CNT_W'(m_free())) begin errors++; $display("FAIL rnd_free_count cyc=%0d got=%0d exp=%0d", cyc, free_count, m_free()); end
      checks++; if (mt_stall !== !exp_acc || mt_dest_tag_valid !== (exp_acc && disp_dest_valid)) begin errors++; $display("FAIL rnd_mt_ctrl cyc=%0d got stall=%0b dtv=%0b exp %0b/%0b", cyc, mt_stall, mt_dest_tag_valid, !exp_acc, exp_acc && disp_dest_valid); end
      checks++; if (mt_dest_tag !== disp_rob_tag || mt_rs2_idx !== disp_rs2_idx) begin errors++; $display("FAIL rnd_mt_fields cyc=%0d got %0d/%0d exp %0d/%0d", cyc, mt_dest_tag, mt_rs2_idx, disp_rob_tag, disp_rs2_idx); end
      checks++; if (iss_valid !== (s >= 0)) begin errors++; $display("FAIL rnd_iss_valid cyc=%0d got=%0b exp=%0b", cyc, iss_valid, s >= 0); end
      if (s >= 0) begin
        checks++; if (iss_rob_tag !== m_rob[s] || iss_payload !== m_pay[s]) begin errors++; $display("FAIL rnd_iss_entry cyc=%0d got tag=%0d pay=%0h exp tag=%0d pay=%0h", cyc, iss_rob_tag, iss_payload, m_rob[s], m_pay[s]); end
        checks++; if (iss_rs1_from_rob !== m_f1[s] || iss_rs2_from_rob !== m_f2[s]) begin errors++; $display("FAIL rnd_from_rob cyc=%0d got %0b%0b exp %0b%0b", cyc, iss_rs1_from_rob, iss_rs2_from_rob, m_f1[s], m_f2[s]); end
        if (m_f1[s]) begin
          checks++; if (iss_rs1_tag !== m_t1[s]) begin errors++; $display("FAIL rnd_rs1_tag cyc=%0d got=%0d exp=%0d", cyc, iss_rs1_tag, m_t1[s]); end
        end
        if (m_f2[s]) begin
          checks++; if (iss_rs2_tag !== m_t2[s]) begin errors++; $display("FAIL rnd_rs2_tag cyc=%0d got=%0d exp=%0d", cyc, iss_rs2_tag, m_t2[s]); end
        end
      end else begin
        checks++; if (iss_rob_tag !== '0 || iss_payload !== '0) begin errors++; $display("FAIL rnd_idle_bus cyc=%0d got tag=%0d pay=%0h exp 0/0", cyc, iss_rob_tag, iss_payload); end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1; iss_ready = 0;
    idle_inputs();
    @(posedge clock); #1;
    test_reset();
    test_basic_issue();
    test_cdb_wakeup();
    test_dispatch_bypass();
    test_full_stall();
    test_hold_and_squash();
    test_age_order();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
